// File: rtl/axis_mux_4_arb.sv
// axis_mux_4_arb: round-robin, frame-locked arbiter driving the axis_mux_4 enable/select pair
module axis_mux_4_arb #(
  parameter int MAX_FRAME_LEN = 1024,
  parameter int CNT_WIDTH     = 16,
  parameter int GAP_CYCLES    = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 arb_enable,
  input  logic                 input_0_axis_tvalid,
  input  logic                 input_1_axis_tvalid,
  input  logic                 input_2_axis_tvalid,
  input  logic                 input_3_axis_tvalid,
  input  logic                 output_axis_tvalid,
  input  logic                 output_axis_tready,
  input  logic                 output_axis_tlast,
  output logic                 enable,
  output logic [1:0]           select,
  output logic                 grant_active,
  output logic [CNT_WIDTH-1:0] frame_count,
  output logic                 timeout_err
);
  typedef enum logic [1:0] {IDLE, BUSY, GAP} state_t;
  localparam logic [CNT_WIDTH-1:0] MAX_C = CNT_WIDTH'(MAX_FRAME_LEN);
  localparam logic [3:0] GAP_LAST = 4'(GAP_CYCLES == 0 ? 0 : GAP_CYCLES - 1);
  state_t               state;
  logic [3:0]           req;
  logic [1:0]           last_grant, win, p1, p2, p3;
  logic [3:0]           gap_cnt;
  logic [CNT_WIDTH-1:0] beat_cnt, beat_nxt;
  logic                 fired, beat;
  assign req = {input_3_axis_tvalid, input_2_axis_tvalid, input_1_axis_tvalid, input_0_axis_tvalid};
  assign beat = output_axis_tvalid && output_axis_tready;
  assign grant_active = enable;
  // Round-robin pick starting one past the previous winner; saturating beat count
  always_comb begin
    p1 = last_grant + 2'd1;
    p2 = last_grant + 2'd2;
    p3 = last_grant + 2'd3;
    win = req[p1] ? p1 : req[p2] ? p2 : req[p3] ? p3 : last_grant;
    beat_nxt = &beat_cnt ? beat_cnt : beat_cnt + 1'b1;
  end
  // Grant FSM: IDLE arbitrates, BUSY holds the grant until tlast, GAP spaces frames
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      enable      <= 1'b0;
      select      <= 2'd0;
      last_grant  <= 2'd3;
      frame_count <= '0;
      timeout_err <= 1'b0;
      beat_cnt    <= '0;
      gap_cnt     <= '0;
      fired       <= 1'b0;
    end else begin
      timeout_err <= 1'b0;
      case (state)
        IDLE: if (arb_enable && |req) begin
          select   <= win;
          enable   <= 1'b1;
          beat_cnt <= '0;
          fired    <= 1'b0;
          state    <= BUSY;
        end
        BUSY: if (beat) begin
          if (output_axis_tlast) begin
            enable      <= 1'b0;
            frame_count <= frame_count + 1'b1;
            last_grant  <= select;
            beat_cnt    <= '0;
            gap_cnt     <= '0;
            state       <= GAP_CYCLES > 0 ? GAP : IDLE;
          end else begin
            beat_cnt <= beat_nxt;
            if (beat_nxt == MAX_C && !fired) begin
              timeout_err <= 1'b1;
              fired       <= 1'b1;
            end
          end
        end
        GAP: begin
          gap_cnt <= gap_cnt + 1'b1;
          if (gap_cnt == GAP_LAST) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
